// File: rtl/fixed_point_pkg.sv
// Shared types and helpers for the fixed-point accumulate/requantize stages.
// Provides the accumulator FSM states, accumulator width and saturation limits.
package fixed_point_pkg;

    typedef enum logic [1:0] {
        S_ACC = 2'd0,
        S_RND = 2'd1,
        S_OUT = 2'd2
    } acc_state_e;

    function automatic int acc_width(input int prod_w, input int guard);
        return prod_w + guard;
    endfunction

    // Valid for widths up to 63 bits.
    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/fixed_point_accumulator_if.sv
// Product-in / word-out valid-ready bundle around fixed_point_accumulator.
// slave: the accumulator view; master: the upstream/downstream view.
interface fixed_point_accumulator_if #(
    parameter int PROD_WIDTH = 32,
    parameter int WORD_WIDTH = 16
);
    logic [PROD_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic [WORD_WIDTH-1:0] out_data;
    logic                  out_sat;
    logic                  out_valid;
    logic                  out_ready;

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_sat, out_valid
    );

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_sat, out_valid
    );
endinterface

// File: rtl/fixed_point_round_sat.sv
// Combinational requantizer: round-half-up by FRAC_BITS, then saturate to OUT_WIDTH.
// Ports: acc_in (signed IN_WIDTH), data_out (signed OUT_WIDTH), sat_out (clipped flag).
module fixed_point_round_sat
    import fixed_point_pkg::*;
#(
    parameter int IN_WIDTH  = 40,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 8
) (
    input  logic signed [IN_WIDTH-1:0]  acc_in,
    output logic signed [OUT_WIDTH-1:0] data_out,
    output logic                        sat_out
);
    // One extra bit so the rounding add can never wrap.
    localparam int EW = IN_WIDTH + 1;
    localparam logic signed [EW-1:0] MAX_V = EW'(sat_max(OUT_WIDTH));
    localparam logic signed [EW-1:0] MIN_V = EW'(sat_min(OUT_WIDTH));

    logic signed [EW-1:0] ext;
    logic signed [EW-1:0] rnd;

    assign ext = {acc_in[IN_WIDTH-1], acc_in};

    if (FRAC_BITS > 0) begin : g_rnd
        localparam logic signed [EW-1:0] HALF = EW'(1) <<< (FRAC_BITS - 1);
        logic signed [EW-1:0] sum;
        assign sum = ext + HALF;
        assign rnd = sum >>> FRAC_BITS;
    end else begin : g_pass
        assign rnd = ext;
    end

    always_comb begin
        sat_out  = 1'b0;
        data_out = rnd[OUT_WIDTH-1:0];
        if (rnd > MAX_V) begin
            sat_out  = 1'b1;
            data_out = MAX_V[OUT_WIDTH-1:0];
        end else if (rnd < MIN_V) begin
            sat_out  = 1'b1;
            data_out = MIN_V[OUT_WIDTH-1:0];
        end
    end

endmodule

// File: rtl/fixed_point_accumulator.sv
// Sums a window of cfg_acc_len signed products, then rounds/saturates to a Q-format word.
// Ports: clk, rst_n (async low), cfg_acc_len, bus (slave: in_* products, out_* words).
module fixed_point_accumulator
    import fixed_point_pkg::*;
#(
    parameter int WORD_WIDTH_IN = 16,
    parameter int PROD_WIDTH    = 2 * WORD_WIDTH_IN,
    parameter int FRAC_BITS     = 8,
    parameter int ACC_GUARD     = 8,
    parameter int LEN_WIDTH     = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [LEN_WIDTH-1:0] cfg_acc_len,
    fixed_point_accumulator_if.slave bus
);
    localparam int ACC_WIDTH = acc_width(PROD_WIDTH, ACC_GUARD);

    // Guard bits must cover the longest window so the sum cannot overflow.
    if (LEN_WIDTH > ACC_GUARD) begin : g_bad_len
        $fatal(1, "LEN_WIDTH must not exceed ACC_GUARD");
    end

    acc_state_e                  state_q, state_d;
    logic signed [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [LEN_WIDTH-1:0]        cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]        len_q, len_d;
    logic [WORD_WIDTH_IN-1:0]    out_data_q, out_data_d;
    logic                        out_sat_q, out_sat_d;

    logic signed [ACC_WIDTH-1:0]     in_ext;
    logic signed [WORD_WIDTH_IN-1:0] rs_data;
    logic                            rs_sat;
    logic [LEN_WIDTH-1:0]            cfg_len;
    logic [LEN_WIDTH-1:0]            eff_len;
    logic                            accept;
    logic                            last;

    assign in_ext = {{ACC_GUARD{bus.in_data[PROD_WIDTH-1]}}, bus.in_data};

    // A zero length acts as a one-beat window.
    assign cfg_len = (cfg_acc_len == '0) ? LEN_WIDTH'(1) : cfg_acc_len;
    // Length is live on the first beat, latched for the rest of the window.
    assign eff_len = (cnt_q == '0) ? cfg_len : len_q;
    assign last    = (cnt_q == eff_len - LEN_WIDTH'(1));

    assign bus.in_ready  = rst_n && (state_q == S_ACC);
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.out_valid = (state_q == S_OUT);
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    fixed_point_round_sat #(
        .IN_WIDTH  (ACC_WIDTH),
        .OUT_WIDTH (WORD_WIDTH_IN),
        .FRAC_BITS (FRAC_BITS)
    ) u_round_sat (
        .acc_in   (acc_q),
        .data_out (rs_data),
        .sat_out  (rs_sat)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        cnt_d      = cnt_q;
        len_d      = len_q;
        out_data_d = out_data_q;
        out_sat_d  = out_sat_q;
        unique case (state_q)
            S_ACC: begin
                if (accept) begin
                    acc_d = acc_q + in_ext;
                    if (cnt_q == '0) begin
                        len_d = cfg_len;
                    end
                    if (last) begin
                        state_d = S_RND;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + LEN_WIDTH'(1);
                    end
                end
            end
            S_RND: begin
                out_data_d = rs_data;
                out_sat_d  = rs_sat;
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (bus.out_ready) begin
                    acc_d   = '0;
                    state_d = S_ACC;
                end
            end
            default: begin
                state_d = S_ACC;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_ACC;
            acc_q      <= '0;
            cnt_q      <= '0;
            len_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            len_q      <= len_d;
            out_data_q <= out_data_d;
            out_sat_q  <= out_sat_d;
        end
    end

endmodule

// File: doc/fixed_point_accumulator.md
Name: fixed_point_accumulator

Overview:
- Stage directly downstream of fixed_point_mult in the convolution datapath.
- Consumes the full-width signed products and sums a window of cfg_acc_len products, for example one kernel dot-product.
- Rounds the sum back to WORD_WIDTH_IN Q-format, saturates it, and hands it to the next stage.
- Valid/ready handshake on both sides.

Parameters:
- WORD_WIDTH_IN, 16: width of the output word; equals the multiplier input width.
- PROD_WIDTH, 2*WORD_WIDTH_IN: width of the incoming product.
- FRAC_BITS, 8: fractional bits of the operands. The product carries 2*FRAC_BITS fractional bits; the output carries FRAC_BITS.
- ACC_GUARD, 8: extra accumulator guard bits. Accumulator width ACC_WIDTH = PROD_WIDTH + ACC_GUARD.
- LEN_WIDTH, 8: width of cfg_acc_len. Elaboration assertion: LEN_WIDTH <= ACC_GUARD.

Ports:
- clk, input, 1: clock.
- rst_n, input, 1: asynchronous active-low reset.
- cfg_acc_len, input, LEN_WIDTH: number of products per window. Sampled on the first accepted beat of each window.
- in_data, input, PROD_WIDTH: signed product from fixed_point_mult.
- in_valid, input, 1: in_data valid.
- in_ready, output, 1: accumulator can accept in_data.
- out_data, output, WORD_WIDTH_IN: signed, rounded, saturated window sum.
- out_sat, output, 1: out_data was clipped.
- out_valid, output, 1: out_data/out_sat valid.
- out_ready, input, 1: downstream accepts the output.

Behaviour:
- Reset:
  - One clock, clk. Reset rst_n is asynchronous, active-low.
  - On reset: state = S_ACC, acc = 0, cnt = 0, len_q = 0, out_data = 0, out_sat = 0, out_valid = 0.
  - in_ready is 0 while rst_n = 0 and 1 on the first cycle after release.
  - Reset mid-window or mid-output discards all partial state; no output is produced for that window.
- States: S_ACC, S_RND, S_OUT (enum in package).
- S_ACC:
  - in_ready = 1, out_valid = 0.
  - On in_valid & in_ready: acc <= acc + sign_extend(in_data).
  - If cnt == 0, len_q <= max(cfg_acc_len, 1); cfg_acc_len = 0 is treated as 1.
  - If this beat is the last (cnt == eff_len-1): go to S_RND, cnt <= 0. Otherwise cnt <= cnt+1.
  - eff_len is the live cfg value on the first beat and len_q afterwards.
  - cfg_acc_len changes mid-window are ignored.
- S_RND:
  - in_ready = 0.
  - Register out_data/out_sat from the round/saturate function of acc, then go to S_OUT.
- S_OUT:
  - out_valid = 1, in_ready = 0. out_data and out_sat are held stable.
  - On out_ready: out_valid <= 0, acc <= 0, go to S_ACC.
  - out_ready while out_valid = 0 has no effect.
- Latency: last input beat accepted in cycle t gives out_valid high in cycle t+2.
  - Minimum window turnaround is eff_len + 2 cycles, with out_ready held high.
- Round/saturate:
  - If FRAC_BITS > 0: r = (acc + 2^(FRAC_BITS-1)) >>> FRAC_BITS (arithmetic shift, round-half-up toward +inf). If FRAC_BITS = 0: r = acc.
  - Saturation limits: MAX = 2^(WORD_WIDTH_IN-1)-1, MIN = -2^(WORD_WIDTH_IN-1).
  - r > MAX gives out_data = MAX, out_sat = 1.
  - r < MIN gives out_data = MIN, out_sat = 1.
  - Otherwise out_data = r[WORD_WIDTH_IN-1:0], out_sat = 0.
  - The rounding add is done at ACC_WIDTH+1 bits and never wraps.
- Accumulator overflow: impossible by construction, since len <= 2^LEN_WIDTH-1 <= 2^ACC_GUARD.

Decomposition:
- Shared package fixed_point_pkg:
  - acc_state_e typedef (S_ACC, S_RND, S_OUT).
  - function or localparam helpers for the saturation MAX/MIN of a given width.
  - ACC_WIDTH derivation.
- Sub-module fixed_point_round_sat:
  - Combinational, parameters IN_WIDTH, OUT_WIDTH, FRAC_BITS.
  - Ports acc_in, data_out, sat_out.
  - Reused later by other requantization stages.

Test Plan (WORD_WIDTH_IN=16, FRAC_BITS=8):
- Basic sum: cfg_acc_len=3, in_data=65536 (1.0×1.0) ×3, back-to-back, out_ready=1 -> out_data=768 (3.0), out_sat=0, out_valid exactly 2 cycles after the 3rd beat, asserted for one cycle.
- Rounding: cfg_acc_len=1.
  - in_data=128 -> out_data=1.
  - in_data=127 -> 0.
  - in_data=-128 -> 0.
  - in_data=-129 -> -1.
- Saturation:
  - cfg_acc_len=4, in_data=0x4000_0000 ×4 -> out_data=0x7FFF, out_sat=1.
  - cfg_acc_len=4, in_data=0xC000_0000 ×4 -> out_data=0x8000, out_sat=1.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> out_data stable, in_ready=0, in_valid beats not consumed. On out_ready=1 the next window starts with acc=0.
- Config edge cases: cfg_acc_len=0 -> each beat yields one output. cfg_acc_len changed from 4 to 2 after the first beat -> window still 4 beats.
- Reset mid-window: assert rst_n=0 after 2 of 4 beats -> all outputs 0 immediately. A fresh 4-beat window of 256 each -> out_data=4 with no residue.
